// File: rtl/aclu_seq_pkg.sv
// Shared definitions for the ACLU microsequencer.
//   - opcode constants for INSTR[7:4]
//   - 3-bit sequencer state encoding
//   - jump condition encoding (taken from the low two opcode bits)
//   - widths of the ALU function select and operand nibble
package aclu_seq_pkg;

    localparam int SEL_W  = 3;
    localparam int OPND_W = 4;

    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JC   = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b1010;
    localparam logic [3:0] OP_JNZ  = 4'b1011;
    localparam logic [3:0] OP_OUT  = 4'b1100;
    localparam logic [3:0] OP_WAIT = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_FLAG  = 3'd3,
        ST_ADDR  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        JC_ALWAYS = 2'd0,
        JC_CARRY  = 2'd1,
        JC_ZERO   = 2'd2,
        JC_NZERO  = 2'd3
    } jcond_t;

endpackage

// File: rtl/aclu_seq_decode.sv
// Combinational instruction class decoder.
//   opcode    in  4 : INSTR[7:4] of the instruction being decoded
//   is_alu    out 1 : opcode 0sss, ALU operation
//   is_jump   out 1 : JMP/JC/JZ/JNZ (two-byte instruction)
//   jump_cond out 2 : which flag test the jump applies
//   is_out    out 1 : OUT strobe
//   is_wait   out 1 : WAIT n
//   is_halt   out 1 : HALT
// NOP decodes to all flags low.
module aclu_seq_decode
    import aclu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_jump,
    output jcond_t     jump_cond,
    output logic       is_out,
    output logic       is_wait,
    output logic       is_halt
);

    always_comb begin
        is_alu    = ~opcode[3];
        is_jump   = 1'b0;
        jump_cond = JC_ALWAYS;
        is_out    = 1'b0;
        is_wait   = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_JMP:  begin is_jump = 1'b1; jump_cond = JC_ALWAYS; end
            OP_JC:   begin is_jump = 1'b1; jump_cond = JC_CARRY;  end
            OP_JZ:   begin is_jump = 1'b1; jump_cond = JC_ZERO;   end
            OP_JNZ:  begin is_jump = 1'b1; jump_cond = JC_NZERO;  end
            OP_OUT:  is_out  = 1'b1;
            OP_WAIT: is_wait = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/aclu_sequencer.sv
// Fetch/execute microsequencer for the 4-bit accumulator/ALU datapath.
//   CLK    in  1     : system clock, rising edge
//   RST    in  1     : synchronous active-high reset
//   START  in  1     : level, accepted once per assertion in IDLE/HALT
//   INSTR  in  8     : combinational ROM data at PC
//   C      in  1     : datapath carry flag
//   ZERO   in  1     : datapath zero flag
//   PC     out PW    : ROM address
//   ENABLE out 1     : accumulator load strobe (EXEC of ALU op)
//   AC1    out 1     : operand buffer enable (EXEC of ALU op)
//   AC2    out 1     : accumulator output enable (EXEC of OUT)
//   SEL    out 3     : ALU function, held between ALU ops
//   IN     out 4     : operand nibble, held between ALU ops
//   BUSY   out 1     : running (not IDLE/HALT)
//   DONE   out 1     : in HALT
// Every output is a flop whose next value is derived from the next state,
// so a strobe is high exactly during the state it belongs to.
module aclu_sequencer
    import aclu_seq_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [7:0]       INSTR,
    input  logic             C,
    input  logic             ZERO,
    output logic [PW-1:0]    PC,
    output logic             ENABLE,
    output logic             AC1,
    output logic             AC2,
    output logic [SEL_W-1:0] SEL,
    output logic [OPND_W-1:0] IN,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [PW-1:0] PC_INC = PW'(1);

    state_t              state, state_nx;
    logic [PW-1:0]       pc_nx;
    logic [3:0]          ir_op, ir_op_nx;
    logic                cf, cf_nx, zf, zf_nx;
    logic [3:0]          wcnt, wcnt_nx;
    logic                start_seen;
    logic                start_ok;
    logic                enable_nx, ac1_nx, ac2_nx;
    logic [SEL_W-1:0]    sel_nx;
    logic [OPND_W-1:0]   in_nx;
    logic                taken;

    logic [3:0]          dec_op;
    logic                is_alu, is_jump, is_out, is_wait, is_halt;
    jcond_t              jump_cond;

    // In FETCH the instruction is decoded straight off the ROM bus; in the
    // later states of the same instruction the latched opcode is used.
    assign dec_op = (state == ST_FETCH) ? INSTR[7:4] : ir_op;

    aclu_seq_decode u_decode (
        .opcode    (dec_op),
        .is_alu    (is_alu),
        .is_jump   (is_jump),
        .jump_cond (jump_cond),
        .is_out    (is_out),
        .is_wait   (is_wait),
        .is_halt   (is_halt)
    );

    // A START level held across a whole run must not relaunch the program
    // once it halts; it has to drop before it can be accepted again.
    assign start_ok = START & ~start_seen;

    always_comb begin
        state_nx  = state;
        pc_nx     = PC;
        ir_op_nx  = ir_op;
        cf_nx     = cf;
        zf_nx     = zf;
        wcnt_nx   = wcnt;
        enable_nx = 1'b0;
        ac1_nx    = 1'b0;
        ac2_nx    = 1'b0;
        sel_nx    = SEL;
        in_nx     = IN;
        taken     = 1'b0;

        case (state)
            ST_IDLE, ST_HALT: begin
                if (start_ok) begin
                    state_nx = ST_FETCH;
                    pc_nx    = '0;
                    cf_nx    = 1'b0;
                    zf_nx    = 1'b0;
                end
            end

            ST_FETCH: begin
                ir_op_nx = INSTR[7:4];
                pc_nx    = PC + PC_INC;
                if (is_alu) begin
                    state_nx  = ST_EXEC;
                    enable_nx = 1'b1;
                    ac1_nx    = 1'b1;
                    sel_nx    = INSTR[6:4];
                    in_nx     = INSTR[3:0];
                end else if (is_jump) begin
                    state_nx = ST_ADDR;
                end else if (is_out) begin
                    state_nx = ST_EXEC;
                    ac2_nx   = 1'b1;
                end else if (is_wait) begin
                    // n stall cycles: counter counts n-1 down to 0 in WAIT.
                    if (INSTR[3:0] == 4'd0) begin
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = ST_WAIT;
                        wcnt_nx  = INSTR[3:0] - 4'd1;
                    end
                end else if (is_halt) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_FETCH;
                end
            end

            ST_EXEC: begin
                state_nx = is_alu ? ST_FLAG : ST_FETCH;
            end

            // Flags are sampled one cycle after ENABLE, once the accumulator
            // holds the new result.
            ST_FLAG: begin
                cf_nx    = C;
                zf_nx    = ZERO;
                state_nx = ST_FETCH;
            end

            ST_ADDR: begin
                case (jump_cond)
                    JC_ALWAYS: taken = 1'b1;
                    JC_CARRY:  taken = cf;
                    JC_ZERO:   taken = zf;
                    JC_NZERO:  taken = ~zf;
                    default:   taken = 1'b0;
                endcase
                pc_nx    = taken ? PW'(INSTR) : (PC + PC_INC);
                state_nx = ST_FETCH;
            end

            ST_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nx = ST_FETCH;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            PC         <= '0;
            cf         <= 1'b0;
            zf         <= 1'b0;
            wcnt       <= 4'd0;
            start_seen <= 1'b0;
            ENABLE     <= 1'b0;
            AC1        <= 1'b0;
            AC2        <= 1'b0;
            SEL        <= '0;
            IN         <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_nx;
            PC         <= pc_nx;
            cf         <= cf_nx;
            zf         <= zf_nx;
            wcnt       <= wcnt_nx;
            start_seen <= START & (start_seen | (start_ok &&
                          (state == ST_IDLE || state == ST_HALT)));
            ENABLE     <= enable_nx;
            AC1        <= ac1_nx;
            AC2        <= ac2_nx;
            SEL        <= sel_nx;
            IN         <= in_nx;
            BUSY       <= (state_nx != ST_IDLE) && (state_nx != ST_HALT);
            DONE       <= (state_nx == ST_HALT);
        end
    end

    // The opcode latch is only read in states reached through FETCH, so it
    // needs no reset.
    always_ff @(posedge CLK) begin
        ir_op <= ir_op_nx;
    end

endmodule

// File: tb/tb_aclu_sequencer.sv
module tb_aclu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] instr;
    logic       c;
    logic       zero;
    logic [7:0] pc;
    logic       enable, ac1, ac2, busy, done;
    logic [2:0] sel;
    logic [3:0] in_n;

    logic [7:0] rom [256];

    int n_tests;
    int n_fail;

    assign instr = rom[pc];

    aclu_sequencer #(.PW(8)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .INSTR  (instr),
        .C      (c),
        .ZERO   (zero),
        .PC     (pc),
        .ENABLE (enable),
        .AC1    (ac1),
        .AC2    (ac2),
        .SEL    (sel),
        .IN     (in_n),
        .BUSY   (busy),
        .DONE   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        rst   = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Launch, then count cycles until DONE (launch cycle is cycle 1).
    task automatic run_prog(output int cyc);
        launch();
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int viol;
    logic prev_en;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; start = 1'b0; c = 1'b0; zero = 1'b0;
        fill_rom();

        // Reset state
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_enable", enable, 0);
        chk("rst_ac1", ac1, 0);
        chk("rst_ac2", ac2, 0);
        chk("rst_sel", sel, 0);
        chk("rst_in", in_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // ALU op, OUT, HALT
        rom[0] = 8'h05; rom[1] = 8'hC0; rom[2] = 8'hFF;
        launch();                                   // cycle 1: FETCH 0
        chk("p1_c1_pc", pc, 0);
        chk("p1_c1_busy", busy, 1);
        chk("p1_c1_enable", enable, 0);
        tick();                                     // cycle 2: EXEC
        chk("p1_c2_enable", enable, 1);
        chk("p1_c2_ac1", ac1, 1);
        chk("p1_c2_ac2", ac2, 0);
        chk("p1_c2_in", in_n, 5);
        chk("p1_c2_sel", sel, 0);
        tick();                                     // cycle 3: FLAG
        chk("p1_c3_enable", enable, 0);
        chk("p1_c3_ac1", ac1, 0);
        tick();                                     // cycle 4: FETCH 1
        chk("p1_c4_pc", pc, 1);
        tick();                                     // cycle 5: EXEC OUT
        chk("p1_c5_ac2", ac2, 1);
        chk("p1_c5_ac1", ac1, 0);
        chk("p1_c5_in_hold", in_n, 5);
        tick();                                     // cycle 6: FETCH 2
        chk("p1_c6_ac2", ac2, 0);
        chk("p1_c6_done", done, 0);
        tick();                                     // cycle 7: HALT
        chk("p1_c7_done", done, 1);
        chk("p1_c7_busy", busy, 0);
        chk("p1_c7_pc", pc, 3);

        // OUT keeps SEL/IN of the last ALU op
        do_reset(); fill_rom();
        rom[0] = 8'h3A; rom[1] = 8'hC0; rom[2] = 8'hFF;
        launch(); tick();
        chk("p2_alu_sel", sel, 3);
        chk("p2_alu_in", in_n, 4'hA);
        tick(); tick(); tick();
        chk("p2_out_ac2", ac2, 1);
        chk("p2_out_sel", sel, 3);

        // JZ taken
        do_reset(); fill_rom();
        rom[0] = 8'h20; rom[1] = 8'hA0; rom[2] = 8'h10; rom[8'h10] = 8'hFF;
        zero = 1'b1;
        launch();
        chk("jz_t_pc0", pc, 0);
        tick(); tick(); tick();
        chk("jz_t_pc1", pc, 1);
        tick();
        chk("jz_t_pc2", pc, 2);
        tick();
        chk("jz_t_pc3", pc, 8'h10);
        tick();
        chk("jz_t_done", done, 1);

        // Restart from HALT clears flags: JZ before any ALU op falls through
        rom[0] = 8'hA0; rom[1] = 8'h20; rom[8'h20] = 8'hFF; rom[2] = 8'hFF;
        run_prog(cyc);
        chk("restart_cyc", cyc, 4);
        chk("restart_pc", pc, 3);

        // JZ not taken
        do_reset(); fill_rom();
        rom[0] = 8'h20; rom[1] = 8'hA0; rom[2] = 8'h10;
        zero = 1'b0;
        launch(); tick(); tick(); tick(); tick(); tick();
        chk("jz_nt_pc", pc, 3);
        tick();
        chk("jz_nt_done", done, 1);

        // JC / JNZ / JMP, target 0x30
        for (int k = 0; k < 5; k++) begin
            logic [7:0] op;
            logic       cin, zin;
            logic [7:0] exp_pc;
            case (k)
                0: begin op = 8'h90; cin = 1; zin = 0; exp_pc = 8'h31; end
                1: begin op = 8'h90; cin = 0; zin = 0; exp_pc = 8'h04; end
                2: begin op = 8'hB0; cin = 0; zin = 0; exp_pc = 8'h31; end
                3: begin op = 8'hB0; cin = 0; zin = 1; exp_pc = 8'h04; end
                default: begin op = 8'h80; cin = 0; zin = 1; exp_pc = 8'h31; end
            endcase
            do_reset(); fill_rom();
            rom[0] = 8'h20; rom[1] = op; rom[2] = 8'h30;
            c = cin; zero = zin;
            run_prog(cyc);
            chk($sformatf("jump%0d_pc", k), pc, exp_pc);
            chk($sformatf("jump%0d_cyc", k), cyc, 7);
        end
        c = 1'b0; zero = 1'b0;

        // WAIT / NOP cycle counts
        do_reset(); fill_rom();
        rom[0] = 8'hD3;
        run_prog(cyc);
        chk("wait3_cyc", cyc, 6);
        do_reset(); fill_rom();
        rom[0] = 8'hD0;
        run_prog(cyc);
        chk("wait0_cyc", cyc, 3);
        do_reset(); fill_rom();
        rom[0] = 8'hDF;
        run_prog(cyc);
        chk("wait15_cyc", cyc, 18);
        do_reset(); fill_rom();
        rom[0] = 8'hE0;
        run_prog(cyc);
        chk("nop_cyc", cyc, 3);

        // START held high is accepted only once
        do_reset(); fill_rom();
        rom[0] = 8'hE0;
        start = 1'b1;
        tick(); tick(); tick();
        chk("hold_done", done, 1);
        tick(); tick();
        chk("hold_still_done", done, 1);
        chk("hold_pc", pc, 2);
        start = 1'b0;

        // PC wrap: jump at 0xFF takes its target from 0x00
        do_reset(); fill_rom();
        rom[0] = 8'h40; rom[1] = 8'h80; rom[2] = 8'hFF;
        rom[8'hFF] = 8'h80; rom[8'h40] = 8'hFF;
        launch(); tick();
        chk("wrap_sel", sel, 4);
        tick(); tick(); tick(); tick();
        chk("wrap_pc_ff", pc, 8'hFF);
        tick();
        chk("wrap_pc_00", pc, 8'h00);
        tick();
        chk("wrap_pc_40", pc, 8'h40);
        tick();
        chk("wrap_done", done, 1);

        // Reset during EXEC of an ALU op
        do_reset(); fill_rom();
        rom[0] = 8'h05; rom[1] = 8'hC0; rom[2] = 8'hFF;
        launch(); tick();
        chk("rx_enable_before", enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_enable", enable, 0);
        chk("rx_ac1", ac1, 0);
        chk("rx_pc", pc, 0);
        chk("rx_busy", busy, 0);
        tick();
        chk("rx_idle_stays", busy, 0);
        launch();
        chk("rx_restart_pc", pc, 0);
        tick();
        chk("rx_restart_enable", enable, 1);
        tick(); tick(); tick(); tick(); tick();
        chk("rx_restart_done", done, 1);

        // Random programs: no bus contention, ENABLE always a lone AC1 pulse
        for (int p = 0; p < 8; p++) begin
            do_reset();
            for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
            viol = 0;
            prev_en = 1'b0;
            for (int t = 0; t < 300; t++) begin
                start = done | (t == 0);
                c     = 1'($urandom_range(0, 1));
                zero  = 1'($urandom_range(0, 1));
                tick();
                start = 1'b0;
                if (ac1 && ac2) viol++;
                if (enable !== ac1) viol++;
                if (enable && prev_en) viol++;
                if (enable && !busy) viol++;
                prev_en = enable;
            end
            chk($sformatf("rand%0d_contention", p), viol, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
